// File: rtl/ysyx_040729_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_040729_pkg
//   Constants and types shared by the IFU and IDU of the ysyx_040729 core:
//   default datapath widths, the reset fetch address, the canonical nop
//   encoding (addi x0, x0, 0) and the 2-bit IFU state encoding.
// ---------------------------------------------------------------------------
package ysyx_040729_pkg;

  localparam int          DEF_INST_WIDTH = 32;
  localparam int          DEF_ADDR_WIDTH = 64;
  localparam logic [63:0] DEF_RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // one bubble after reset release
    S_REQ  = 2'd1,  // presenting a read request to instruction memory
    S_WAIT = 2'd2,  // request accepted, waiting for the response pulse
    S_HOLD = 2'd3   // {if_pc, if_inst} valid, waiting for the decoder
  } ifu_state_e;

endpackage

// File: rtl/ysyx_040729_reg.sv
// ---------------------------------------------------------------------------
// ysyx_040729_reg
//   Generic register cell used for datapath state across the core.
//   Synchronous active-low reset to RESET_VAL; loads din when wen is high.
// Ports
//   clk    in   1      clock
//   rst_n  in   1      synchronous active-low reset
//   wen    in   1      write enable
//   din    in   WIDTH  next value
//   dout   out  WIDTH  registered value
// ---------------------------------------------------------------------------
module ysyx_040729_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // NOTE: state is written with <= so every flop samples the pre-edge values;
  // a blocking = here would let later logic in the same block see the new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_040729_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_040729_ifu_fetch
//   Instruction fetch stage in front of the IDU. Keeps the PC, issues one
//   instruction-memory read at a time and hands {pc, inst} to the decoder
//   over a valid/ready handshake. Redirects from EXU/CSR restart fetch at a
//   new PC and squash any wrong-path instruction, including a response that
//   is still in flight (tracked by the drop flag).
//
// Configuration macro: YSYX_040729_IFU_MISALIGN_CHECK_EN
//   defined   : a redirect to a PC with [1:0] != 0 issues no memory read; the
//               stage presents a nop with if_misalign=1 at that PC instead.
//   undefined : if_misalign is tied 0 and every PC load is forced to a
//               4-byte boundary.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   imem_req_*        read request (valid/ready, addr)
//   imem_resp_*       read response (one valid pulse per accepted request)
//   redirect_valid/pc flush and restart fetch at redirect_pc
//   if_valid/ready    handshake toward the decoder
//   if_pc, if_inst    instruction and its PC
//   if_misalign       if_inst is a substituted nop for a misaligned fetch
// ---------------------------------------------------------------------------
module ysyx_040729_ifu_fetch
  import ysyx_040729_pkg::*;
#(
  parameter int                INST_WIDTH = DEF_INST_WIDTH,
  parameter int                ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [63:0]       RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic                  if_misalign
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  ifu_state_e state_q, state_d;
  logic       drop_q, drop_d;
  logic       if_valid_d;
  logic       req_valid_d;

  logic                  pc_wen;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  out_wen;
  logic [ADDR_WIDTH-1:0] if_pc_d;
  logic [INST_WIDTH-1:0] if_inst_d;
  logic                  if_misalign_d;

  logic req_fire;
  logic inflight;
  logic inflight_after;
  logic redirect_bad;

  // Value actually written into the PC register on any load.
  function automatic logic [ADDR_WIDTH-1:0] pc_fix(input logic [ADDR_WIDTH-1:0] pc_in);
`ifdef YSYX_040729_IFU_MISALIGN_CHECK_EN
    // Misaligned targets are kept verbatim so the trap PC and the +4
    // continuation after the substituted nop both refer to the original target.
    return pc_in;
`else
    return pc_in & ALIGN_MASK;
`endif
  endfunction

`ifdef YSYX_040729_IFU_MISALIGN_CHECK_EN
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  assign req_fire = imem_req_valid && imem_req_ready;

  // A read is outstanding if we are waiting for it, or an earlier one was
  // squashed and its response has not shown up yet.
  assign inflight       = (state_q == S_WAIT) || drop_q;
  // Still outstanding after this edge: a request accepted now, or the current
  // one if its response does not arrive this cycle.
  assign inflight_after = req_fire || (inflight && !imem_resp_valid);

  assign imem_req_addr = pc_q;

  // NOTE: every signal driven here gets a default at the top, so no path
  // through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    if_valid_d    = if_valid;
    pc_wen        = 1'b0;
    pc_d          = pc_q;
    out_wen       = 1'b0;
    if_pc_d       = if_pc;
    if_inst_d     = if_inst;
    if_misalign_d = if_misalign;

    if (state_q == S_IDLE) begin
      state_d = S_REQ;
    end else if (redirect_valid) begin
      // Redirect outranks everything: load the target and squash whatever
      // the stage holds. A request already accepted must have its response
      // swallowed, so drop follows whether one remains outstanding.
      pc_wen = 1'b1;
      pc_d   = pc_fix(redirect_pc);
      drop_d = inflight_after;
      if (redirect_bad) begin
        state_d       = S_HOLD;
        if_valid_d    = 1'b1;
        out_wen       = 1'b1;
        if_pc_d       = redirect_pc;
        if_inst_d     = INST_WIDTH'(NOP_INST);
        if_misalign_d = 1'b1;
      end else begin
        // Wait out an in-flight read before issuing the new one so that at
        // most one request is ever outstanding.
        state_d       = inflight_after ? S_WAIT : S_REQ;
        if_valid_d    = 1'b0;
        if_misalign_d = 1'b0;
      end
    end else begin
      // A squashed response can only arrive outside S_WAIT when a misaligned
      // redirect moved us to S_HOLD with a read in flight.
      if (drop_q && imem_resp_valid) begin
        drop_d = 1'b0;
      end
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              state_d = S_REQ;  // pc already holds the redirect target
            end else begin
              state_d       = S_HOLD;
              if_valid_d    = 1'b1;
              out_wen       = 1'b1;
              if_pc_d       = pc_q;
              if_inst_d     = imem_resp_data;
              if_misalign_d = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (if_ready) begin
            pc_wen        = 1'b1;
            pc_d          = pc_fix(pc_q + PC_STEP);
            if_valid_d    = 1'b0;
            if_misalign_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        default: ;
      endcase
    end

    // Request valid is registered; it is held off while a squashed read is
    // still outstanding.
    req_valid_d = (state_d == S_REQ) && !drop_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      drop_q         <= 1'b0;
      if_valid       <= 1'b0;
      imem_req_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      drop_q         <= drop_d;
      if_valid       <= if_valid_d;
      imem_req_valid <= req_valid_d;
    end
  end

  ysyx_040729_reg #(
    .WIDTH     (ADDR_WIDTH),
    .RESET_VAL (ADDR_WIDTH'(RESET_PC))
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (pc_wen),
    .din   (pc_d),
    .dout  (pc_q)
  );

  ysyx_040729_reg #(
    .WIDTH     (ADDR_WIDTH),
    .RESET_VAL ('0)
  ) u_if_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (out_wen),
    .din   (if_pc_d),
    .dout  (if_pc)
  );

  ysyx_040729_reg #(
    .WIDTH     (INST_WIDTH),
    .RESET_VAL ('0)
  ) u_if_inst_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (out_wen),
    .din   (if_inst_d),
    .dout  (if_inst)
  );

  ysyx_040729_reg #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_if_misalign_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (1'b1),
    .din   (if_misalign_d),
    .dout  (if_misalign)
  );

endmodule
